// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and default word width.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Full adder built from two half adders plus an OR for the carry.
// Ports: a, b, cin (operand bits and carry-in); sum_c, cout_c (sum bit, carry-out).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum_c,
    output logic cout_c
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a       (a),
        .b       (b),
        .sum_c   (s0),
        .carry_c (c0)
    );

    half_adder u_ha1 (
        .a       (s0),
        .b       (cin),
        .sum_c   (sum_c),
        .carry_c (c1)
    );

    // At most one half adder can generate a carry, so OR suffices.
    assign cout_c = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Half adder: one-bit sum and carry of two inputs.
// Ports: a, b (operands); sum_c (a^b); carry_c (a&b).
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum_c,
    output logic carry_c
);

    assign sum_c   = a ^ b;
    assign carry_c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two LSB-first operand streams one bit per accepted cycle,
// emitting each sum bit with one cycle of latency and the parallel result per word.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid, in_first    bit-pair qualifier and start-of-word marker
//   a, b                  serial operand bits, LSB first
//   sum, sum_valid        registered serial sum bit and its strobe
//   result, carry_out     parallel sum and final carry of the last completed word
//   done                  one-cycle pulse when result/carry_out load
//   busy                  high while a word is partially received
//   restart               one-cycle pulse when a partial word is abandoned
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             a,
    input  logic             b,
    output logic             sum,
    output logic             sum_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             done,
    output logic             busy,
    output logic             restart
);

    localparam int unsigned IDX_W = $clog2(WIDTH + 1);

    state_t           state;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] shreg;

    logic             accept_c;
    logic             cin_c;
    logic [IDX_W-1:0] idx_nxt_c;
    logic             last_c;
    logic             s_c;
    logic             cout_c;

    // A first bit always starts a fresh word with carry-in 0; otherwise continue the word.
    always_comb begin
        accept_c  = in_valid && (in_first || (state == ADD));
        cin_c     = 1'b0;
        idx_nxt_c = IDX_W'(1);
        if ((state == ADD) && !in_first) begin
            cin_c     = carry;
            idx_nxt_c = idx + IDX_W'(1);
        end
        last_c = (idx_nxt_c == IDX_W'(WIDTH));
    end

    full_adder u_fa (
        .a      (a),
        .b      (b),
        .cin    (cin_c),
        .sum_c  (s_c),
        .cout_c (cout_c)
    );

    // FSM, carry, bit index, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            carry     <= 1'b0;
            idx       <= '0;
            shreg     <= '0;
            sum       <= 1'b0;
            sum_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            restart   <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            done      <= 1'b0;
            restart   <= 1'b0;
            if (accept_c) begin
                sum       <= s_c;
                sum_valid <= 1'b1;
                // Shift in from the top so bit 0 of the word lands at shreg[0] after WIDTH bits.
                shreg     <= {s_c, shreg[WIDTH-1:1]};
                if ((state == ADD) && in_first) begin
                    restart <= 1'b1;
                end
                if (last_c) begin
                    result    <= {s_c, shreg[WIDTH-1:1]};
                    carry_out <= cout_c;
                    done      <= 1'b1;
                    state     <= IDLE;
                    busy      <= 1'b0;
                    idx       <= '0;
                    carry     <= 1'b0;
                end else begin
                    state     <= ADD;
                    busy      <= 1'b1;
                    idx       <= idx_nxt_c;
                    carry     <= cout_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_first;
    logic         a;
    logic         b;
    logic         sum;
    logic         sum_valid;
    logic [W-1:0] result;
    logic         carry_out;
    logic         done;
    logic         busy;
    logic         restart;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done_cyc = 0;

    logic [W-1:0] exp_result;
    logic         exp_carry;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .sum_valid (sum_valid),
        .result    (result),
        .carry_out (carry_out),
        .done      (done),
        .busy      (busy),
        .restart   (restart)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Apply one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic step(input logic v, input logic f, input logic x, input logic y);
        in_valid = v;
        in_first = f;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
    endtask

    // One full word with optional 2-cycle stalls after the s1-th and s2-th bits.
    task automatic test_add(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input int s1, input int s2, input logic exp_restart);
        logic [W:0] full;
        logic       want_done;
        logic       want_busy;
        logic       want_rst;
        full = {1'b0, x} + {1'b0, y};
        for (int i = 0; i < W; i++) begin
            step(1'b1, i == 0, x[i], y[i]);
            want_done = (i == W - 1);
            want_busy = (i != W - 1);
            want_rst  = exp_restart && (i == 0);
            checks++;
            if (sum_valid !== 1'b1 || sum !== full[i]) begin
                errors++;
                $display("FAIL %s sum bit %0d: got valid=%b sum=%b, want valid=1 sum=%b",
                         name, i, sum_valid, sum, full[i]);
            end
            checks++;
            if (done !== want_done) begin
                errors++;
                $display("FAIL %s done bit %0d: got %b want %b", name, i, done, want_done);
            end
            checks++;
            if (busy !== want_busy) begin
                errors++;
                $display("FAIL %s busy bit %0d: got %b want %b", name, i, busy, want_busy);
            end
            checks++;
            if (restart !== want_rst) begin
                errors++;
                $display("FAIL %s restart bit %0d: got %b want %b", name, i, restart, want_rst);
            end
            if (i == W - 1) begin
                exp_result    = full[W-1:0];
                exp_carry     = full[W];
                last_done_cyc = cyc;
            end
            checks++;
            if (result !== exp_result || carry_out !== exp_carry) begin
                errors++;
                $display("FAIL %s result bit %0d: got %h/%b want %h/%b",
                         name, i, result, carry_out, exp_result, exp_carry);
            end
            if (i + 1 == s1 || i + 1 == s2) begin
                for (int k = 0; k < 2; k++) begin
                    step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                    checks++;
                    if (sum_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || sum !== full[i]) begin
                        errors++;
                        $display("FAIL %s stall after bit %0d: got valid=%b done=%b busy=%b sum=%b want 0/0/1/%b",
                                 name, i, sum_valid, done, busy, sum, full[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({sum, sum_valid, result, carry_out, done, busy, restart} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got sum=%b sv=%b res=%h co=%b done=%b busy=%b rst=%b want all 0",
                     sum, sum_valid, result, carry_out, done, busy, restart);
        end
        rst_n      = 1'b1;
        exp_result = '0;
        exp_carry  = 1'b0;
        // Idle bits without in_first must be ignored.
        step(1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (sum_valid !== 1'b0 || busy !== 1'b0 || sum !== 1'b0) begin
            errors++;
            $display("FAIL idle ignore: got sv=%b busy=%b sum=%b want 0/0/0", sum_valid, busy, sum);
        end
    endtask

    task automatic test_restart();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i == 0, 1'($urandom), 1'($urandom));
            checks++;
            if (done !== 1'b0 || busy !== 1'b1 || restart !== 1'b0) begin
                errors++;
                $display("FAIL restart prefix bit %0d: got done=%b busy=%b rst=%b want 0/1/0",
                         i, done, busy, restart);
            end
        end
        test_add("restart_word", 8'h01, 8'h01, 0, 0, 1'b1);
    endtask

    task automatic test_midword_reset();
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b1, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        checks++;
        if ({sum, sum_valid, result, carry_out, done, busy, restart} !== '0) begin
            errors++;
            $display("FAIL midword reset: got sum=%b sv=%b res=%h co=%b done=%b busy=%b rst=%b want all 0",
                     sum, sum_valid, result, carry_out, done, busy, restart);
        end
        exp_result = '0;
        exp_carry  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1);
            checks++;
            if (sum_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post-reset ignore %0d: got sv=%b done=%b busy=%b want 0/0/0",
                         i, sum_valid, done, busy);
            end
        end
        test_add("after_reset", 8'h10, 8'h20, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int d1;
        test_add("b2b_first", 8'd7, 8'd9, 0, 0, 1'b0);
        d1 = last_done_cyc;
        test_add("b2b_second", 8'd200, 8'd100, 0, 0, 1'b0);
        checks++;
        if (last_done_cyc - d1 !== 8) begin
            errors++;
            $display("FAIL b2b spacing: got %0d cycles want 8", last_done_cyc - d1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                step(1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
                checks++;
                if (sum_valid !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL random gap %0d: got sv=%b busy=%b want 0/0", n, sum_valid, busy);
                end
            end
            test_add("random", W'($urandom), W'($urandom),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        a        = 1'b0;
        b        = 1'b0;
        exp_result = '0;
        exp_carry  = 1'b0;
        @(negedge clk);
        test_reset();
        test_add("s1_3p5", 8'd3, 8'd5, 0, 0, 1'b0);
        test_add("s2_255p1", 8'd255, 8'd1, 0, 0, 1'b0);
        test_add("s3_stall", 8'hA5, 8'h3C, 2, 5, 1'b0);
        test_restart();
        test_midword_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
